// File: rtl/sprite_fb_blitter.sv
// sprite_fb_blitter: streams a sprite from a synchronous ROM into the frame-buffer index RAM,
// one pixel per clock, skipping transparent pixels and clipping at the right/bottom edges.
module sprite_fb_blitter #(
    parameter int SPR_W  = 21,
    parameter int SPR_H  = 45,
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int IDX_W  = 5,
    parameter int TRANSP = 0
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       pos_x,
    input  logic [6:0]       pos_y,
    output logic             busy,
    output logic             done,
    output logic [10:0]      spr_rom_addr,
    input  logic [IDX_W-1:0] spr_rom_q,
    output logic             fb_we,
    output logic [14:0]      fb_addr,
    output logic [IDX_W-1:0] fb_data
);
    localparam int N  = SPR_W * SPR_H;
    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, state_nx;
    logic [7:0]      px;
    logic [6:0]      py;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [10:0]     addr;
    logic            dcnt;
    logic            last, col_wrap;
    logic [8:0]      x;
    logic [7:0]      y;
    logic            inb;
    logic [14:0]     fa;
    logic            s1_v, s1_inb;
    logic [14:0]     s1_addr;
    logic            wr;

    assign last     = addr == 11'(N - 1);
    assign col_wrap = col == CW'(SPR_W - 1);
    // Wide enough that an off-screen target can never wrap back on-screen
    assign x   = 9'(px) + 9'(col);
    assign y   = 8'(py) + 8'(row);
    assign inb = (x < 9'(FB_W)) && (y < 8'(FB_H));
    assign fa  = 15'(y) * 15'(FB_W) + 15'(x);
    assign wr  = s1_v && s1_inb && (spr_rom_q != IDX_W'(TRANSP));
    assign spr_rom_addr = addr;

    always_ff @(posedge vga_clk)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = last ? DRAIN : RUN;
            DRAIN:   state_nx = dcnt ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DRAIN);
        done = state == DONE;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            px      <= '0;
            py      <= '0;
            col     <= '0;
            row     <= '0;
            addr    <= '0;
            dcnt    <= 1'b0;
            s1_v    <= 1'b0;
            s1_inb  <= 1'b0;
            s1_addr <= '0;
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            if (state == IDLE && start) begin
                px   <= pos_x;
                py   <= pos_y;
                col  <= '0;
                row  <= '0;
                addr <= '0;
            end else if (state == RUN && !last) begin
                addr <= addr + 11'd1;
                col  <= col_wrap ? '0 : col + CW'(1);
                row  <= col_wrap ? row + RW'(1) : row;
            end
            dcnt    <= (state == DRAIN) ? ~dcnt : 1'b0;
            s1_v    <= state == RUN;
            s1_inb  <= inb;
            s1_addr <= fa;
            fb_we   <= wr;
            if (wr) begin
                fb_addr <= s1_addr;
                fb_data <= spr_rom_q;
            end
        end
    end
endmodule

// File: tb/tb_sprite_fb_blitter.sv
// tb_sprite_fb_blitter: directed and randomized blits checked against a loop-based
// reference of which frame-buffer pixels each sprite should paint.
module tb_sprite_fb_blitter;
    localparam int SW = 21, SH = 45, FW = 160, FH = 120, N = SW * SH;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pos_x = '0;
    logic [6:0]  pos_y = '0;
    logic        busy, done, fb_we;
    logic [10:0] spr_rom_addr;
    logic [4:0]  spr_rom_q;
    logic [14:0] fb_addr;
    logic [4:0]  fb_data;

    logic [4:0]  rom [N];
    logic [19:0] got [$];
    logic [19:0] exp_q [$];
    int vectors = 0, miscompares = 0;
    int done_cyc, done_cnt, busy_bad;

    sprite_fb_blitter dut (
        .vga_clk(vga_clk), .reset(reset), .start(start), .pos_x(pos_x), .pos_y(pos_y),
        .busy(busy), .done(done), .spr_rom_addr(spr_rom_addr), .spr_rom_q(spr_rom_q),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
    );

    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) spr_rom_q <= rom[spr_rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    // mode 0: opaque 1+(i%31); 1: even indices transparent; 2: random with ~25% transparent
    task automatic fill_rom(input int mode);
        for (int i = 0; i < N; i++)
            rom[i] = mode == 0 ? 5'(1 + i % 31) :
                     mode == 1 ? ((i % 2 == 1) ? 5'($urandom_range(1, 31)) : 5'd0) :
                     (($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
    endtask

    task automatic build_model(input int px, input int py);
        exp_q.delete();
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++)
                if (px + c < FW && py + r < FH && rom[r * SW + c] != 0)
                    exp_q.push_back({15'((py + r) * FW + px + c), rom[r * SW + c]});
    endtask

    // start accepted at edge 0; cycle c is sampled 1 time unit after edge c-1
    task automatic run_blit(input string tag, input int px, input int py, input int start_at, input bit hold);
        int k;
        build_model(px, py);
        got.delete();
        done_cyc = -1; done_cnt = 0; busy_bad = 0;
        pos_x = 8'(px); pos_y = 7'(py); start = 1'b1;
        step();
        for (int c = 1; c <= N + 5; c++) begin
            start = hold || (c == start_at);
            if (c == 1) check({tag, " addr@1"}, 32'(spr_rom_addr), 0);
            if (fb_we) got.push_back({fb_addr, fb_data});
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c <= N + 3 && busy !== (c <= N + 2)) busy_bad++;
            if (hold && c == N + 5) check({tag, " busy restart"}, 32'(busy), 1);
            step();
        end
        check({tag, " done cycle"}, done_cyc, N + 3);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " busy window"}, busy_bad, 0);
        check({tag, " writes"}, got.size(), exp_q.size());
        k = (got.size() < exp_q.size() ? got.size() : exp_q.size()) - 1;
        for (int i = 0; i <= k; i++)
            if (got[i] !== exp_q[i]) begin k = i; break; end
        if (k >= 0) check({tag, " write data"}, 32'(got[k]), 32'(exp_q[k]));
    endtask

    initial begin
        int tmo;
        repeat (3) step();
        reset = 1'b0;
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset fb_we", 32'(fb_we), 0);
        check("reset addr", 32'(spr_rom_addr), 0);
        step();

        fill_rom(0);
        run_blit("opaque", 0, 0, -1, 0);
        check("opaque count", got.size(), 945);
        if (got.size() == 945) begin
            check("opaque first", 32'(got[0]), 32'({15'd0, 5'd1}));
            check("opaque w22 addr", 32'(got[21][19:5]), 160);
            check("opaque last addr", 32'(got[944][19:5]), 7060);
        end

        fill_rom(1);
        run_blit("transp", 10, 5, -1, 0);
        check("transp count", got.size(), 472);
        if (got.size() > 0) check("transp first addr", 32'(got[0][19:5]), 811);

        fill_rom(0);
        run_blit("rclip", 150, 0, -1, 0);
        check("rclip count", got.size(), 450);
        run_blit("bclip", 0, 100, -1, 0);
        check("bclip count", got.size(), 420);
        if (got.size() > 0) check("bclip max addr", 32'(got[got.size() - 1][19:5]), 19060);
        run_blit("offscreen", 0, 120, -1, 0);
        check("offscreen count", got.size(), 0);
        run_blit("offscreen x", 200, 10, -1, 0);

        fill_rom(2);
        run_blit("start busy", 37, 60, 300, 0);
        run_blit("hold", 5, 7, -1, 1);
        start = 1'b0;
        tmo = 0;
        while (!done && tmo < 2000) begin step(); tmo++; end
        check("hold second done", 32'(tmo < 2000), 1);
        step();

        pos_x = 8'd20; pos_y = 7'd30; start = 1'b1;
        step();
        start = 1'b0;
        repeat (399) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst fb_we", 32'(fb_we), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst done", 32'(done), 0);
        check("midrst addr", 32'(spr_rom_addr), 0);
        tmo = 0;
        for (int i = 0; i < 20; i++) begin
            if (fb_we || busy) tmo++;
            step();
        end
        check("midrst quiet", tmo, 0);
        run_blit("after reset", 20, 30, -1, 0);

        for (int t = 0; t < 6; t++) begin
            fill_rom(2);
            run_blit("random", $urandom_range(0, 170), $urandom_range(0, 127), -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
